// File: rtl/aurora_hls_monitor_pkg.sv
// Shared constants for the Aurora HLS link-health monitor.
package aurora_hls_monitor_pkg;
   localparam int AURORA_STATUS_W = 13;
   localparam logic [AURORA_STATUS_W-1:0] STATUS_OK_DEF = 13'h11FF;
   localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/aurora_hls_monitor_counter.sv
// Level-based event counter with synchronous reset.
// Saturates instead of wrapping when AURORA_HLS_MONITOR_SATURATE_EN is defined.
module aurora_hls_monitor_counter
   import aurora_hls_monitor_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

`ifdef AURORA_HLS_MONITOR_SATURATE_EN
   logic at_max;
   assign at_max = &count_q;

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else if (inc && !at_max)
         count_q <= count_q + 1'b1;
   end
`else
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else if (inc)
         count_q <= count_q + 1'b1;
   end
`endif

   assign count = count_q;

endmodule

// File: rtl/aurora_hls_monitor.sv
// Counts cycles of bad Aurora status and RX/TX FIFO almost-full.
// Build option: AURORA_HLS_MONITOR_SATURATE_EN makes counters saturate.
module aurora_hls_monitor
   import aurora_hls_monitor_pkg::*;
#(
   parameter logic [AURORA_STATUS_W-1:0] STATUS_OK = STATUS_OK_DEF,
   parameter int                         CNT_W     = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AURORA_STATUS_W-1:0] aurora_status,
   input  logic                       fifo_rx_almost_full,
   input  logic                       fifo_tx_almost_full,
   output logic [CNT_W-1:0]           core_status_not_ok_count,
   output logic [CNT_W-1:0]           fifo_rx_overflow_count,
   output logic [CNT_W-1:0]           fifo_tx_overflow_count
);

   logic status_bad;
   assign status_bad = (aurora_status != STATUS_OK);

   aurora_hls_monitor_counter #(.CNT_W(CNT_W)) u_status_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (status_bad),
      .count (core_status_not_ok_count)
   );

   aurora_hls_monitor_counter #(.CNT_W(CNT_W)) u_rx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (fifo_rx_almost_full),
      .count (fifo_rx_overflow_count)
   );

   aurora_hls_monitor_counter #(.CNT_W(CNT_W)) u_tx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (fifo_tx_almost_full),
      .count (fifo_tx_overflow_count)
   );

endmodule

// File: tb/tb_aurora_hls_monitor.sv
// Directed bench for aurora_hls_monitor: 32-bit instance plus a 4-bit
// instance for the wrap/saturate boundary.
module tb_aurora_hls_monitor;
   import aurora_hls_monitor_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] status;
   logic        rx;
   logic        tx;
   logic [31:0] not_ok_cnt;
   logic [31:0] rx_cnt;
   logic [31:0] tx_cnt;

   logic        s_rx;
   logic [3:0]  s_not_ok_cnt;
   logic [3:0]  s_rx_cnt;
   logic [3:0]  s_tx_cnt;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aurora_hls_monitor dut (
      .clk                      (clk),
      .rst                      (rst),
      .aurora_status            (status),
      .fifo_rx_almost_full      (rx),
      .fifo_tx_almost_full      (tx),
      .core_status_not_ok_count (not_ok_cnt),
      .fifo_rx_overflow_count   (rx_cnt),
      .fifo_tx_overflow_count   (tx_cnt)
   );

   aurora_hls_monitor #(.CNT_W(4)) dut_small (
      .clk                      (clk),
      .rst                      (rst),
      .aurora_status            (13'h11FF),
      .fifo_rx_almost_full      (s_rx),
      .fifo_tx_almost_full      (1'b0),
      .core_status_not_ok_count (s_not_ok_cnt),
      .fifo_rx_overflow_count   (s_rx_cnt),
      .fifo_tx_overflow_count   (s_tx_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      status = 13'h11FF;
      rx = 1'b0;
      tx = 1'b0;
      s_rx = 1'b0;
      #1;

      // reset
      step(2);
      check("rst_not_ok", not_ok_cnt, 0);
      check("rst_rx", rx_cnt, 0);
      check("rst_tx", tx_cnt, 0);
      check("rst_small_rx", {28'd0, s_rx_cnt}, 0);
      rst = 1'b0;

      // status
      step(4);
      check("status_ok_hold", not_ok_cnt, 0);
      status = 13'h11FE;
      step(1);
      check("status_latency", not_ok_cnt, 1);
      step(2);
      check("status_bad3", not_ok_cnt, 3);
      status = 13'h11FF;
      step(2);
      check("status_stays3", not_ok_cnt, 3);

      // rx pulses
      for (int i = 0; i < 4; i++) begin
         rx = (i % 2 == 0);
         step(1);
      end
      rx = 1'b0;
      check("rx_pulses", rx_cnt, 2);
      check("rx_not_ok_same", not_ok_cnt, 3);
      check("rx_tx_same", tx_cnt, 0);

      // tx pulses
      for (int i = 0; i < 6; i++) begin
         tx = (i % 2 == 0);
         step(1);
      end
      tx = 1'b0;
      check("tx_pulses", tx_cnt, 3);
      check("tx_rx_same", rx_cnt, 2);

      // simultaneous
      status = 13'h0000;
      rx = 1'b1;
      tx = 1'b1;
      step(5);
      check("sim_not_ok", not_ok_cnt, 8);
      check("sim_rx", rx_cnt, 7);
      check("sim_tx", tx_cnt, 8);

      // reset mid-count, conditions still active
      rst = 1'b1;
      step(1);
      check("mid_rst_not_ok", not_ok_cnt, 0);
      check("mid_rst_rx", rx_cnt, 0);
      check("mid_rst_tx", tx_cnt, 0);
      rst = 1'b0;
      step(1);
      check("resume_not_ok", not_ok_cnt, 1);
      check("resume_rx", rx_cnt, 1);
      check("resume_tx", tx_cnt, 1);

      // single differing bit 12 must count
      status = 13'h01FF;
      rx = 1'b0;
      tx = 1'b0;
      step(1);
      check("exact_cmp", not_ok_cnt, 2);
      check("hold_rx", rx_cnt, 1);
      status = 13'h11FF;

      // 4-bit boundary
      s_rx = 1'b1;
      step(15);
      check("small_all_ones", {28'd0, s_rx_cnt}, 15);
      step(2);
      s_rx = 1'b0;
`ifdef AURORA_HLS_MONITOR_SATURATE_EN
      check("small_17", {28'd0, s_rx_cnt}, 15);
`else
      check("small_17", {28'd0, s_rx_cnt}, 1);
`endif
      check("small_not_ok", {28'd0, s_not_ok_cnt}, 0);
      check("small_tx", {28'd0, s_tx_cnt}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aurora_hls_monitor.md
AURORA_HLS_MONITOR -- requirements
Module: aurora_hls_monitor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter STATUS_OK, default 13'h11FF: the aurora_status value that means healthy.
REQ-003 Parameter CNT_W, default 32: width of every counter output.
REQ-004 Port list, clock and reset first:
- clk  input  1  sole clock; all logic on its rising edge
- rst  input  1  synchronous active-high reset
- aurora_status  input  13  Aurora core status vector
- fifo_rx_almost_full  input  1  RX FIFO almost-full flag
- fifo_tx_almost_full  input  1  TX FIFO almost-full flag
- core_status_not_ok_count  output  CNT_W  cycles with status not OK
- fifo_rx_overflow_count  output  CNT_W  cycles with RX almost-full high
- fifo_tx_overflow_count  output  CNT_W  cycles with TX almost-full high
REQ-005 All inputs SHALL already be synchronous to clk; the module SHALL NOT add synchronizers.

Function
REQ-006 At each rising edge with rst low, core_status_not_ok_count SHALL increment by 1 when aurora_status != STATUS_OK, using an exact 13-bit compare.
REQ-007 At each rising edge with rst low, fifo_rx_overflow_count SHALL increment by 1 when fifo_rx_almost_full is 1.
REQ-008 At each rising edge with rst low, fifo_tx_overflow_count SHALL increment by 1 when fifo_tx_almost_full is 1.
REQ-009 Counting SHALL be level-based: a flag held high for N edges adds N, and separate pulses accumulate.
REQ-010 Outputs SHALL be driven directly from the counter registers.
REQ-011 A condition sampled at edge k SHALL be visible on the output immediately after edge k, so latency is one edge and there is no extra pipeline stage.
REQ-012 The three counters SHALL be fully independent; simultaneous conditions SHALL increment each affected counter by 1 in the same cycle.
REQ-013 Without saturation (REQ-018), a counter SHALL wrap modulo 2^CNT_W, so all-ones + 1 gives 0.
REQ-014 A counter SHALL hold its value in any cycle where its condition is false.

Reset
REQ-015 When rst is 1 at a rising edge, all three counters SHALL become 0, whatever the input values.
REQ-016 Reset SHALL take priority over incrementing, including when asserted mid-count.
REQ-017 In the first edge after rst deasserts, counting SHALL resume normally.

Configuration
REQ-018 When macro AURORA_HLS_MONITOR_SATURATE_EN is defined, each counter SHALL saturate at all-ones and hold there until reset.
REQ-019 When AURORA_HLS_MONITOR_SATURATE_EN is undefined, counters SHALL wrap per REQ-013; all other behaviour is identical in both builds.

Structure
REQ-020 Package aurora_hls_monitor_pkg SHALL hold:
- the STATUS_OK default (13'h11FF)
- the CNT_W default (32)
- AURORA_STATUS_W = 13
REQ-021 One sub-module, aurora_hls_monitor_counter, SHALL be used:
- ports: clk, rst, inc, count[CNT_W]
- implements increment, reset and the wrap/saturate option
- instantiated three times, one per output

Verification
REQ-022 Reset test: hold rst=1 for 2 edges with status=0x11FF and both flags 0 -> all three counts = 0.
REQ-023 Status test: after reset release, hold status=0x11FF for 4 edges, then 0x11FE for 3 edges, then restore 0x11FF -> core_status_not_ok_count = 3, and it stays 3.
REQ-024 RX test: drive rx flag 1,0,1,0 over 4 edges -> fifo_rx_overflow_count = 2, and the other counts are unchanged.
REQ-025 TX test: drive tx flag 1,0,1,0,1,0 over 6 edges -> fifo_tx_overflow_count = 3.
REQ-026 Simultaneous and mid-count reset test:
- bad status and both flags high for 5 edges -> each count rises by 5
- then rst=1 for 1 edge -> all counts = 0
REQ-027 Wrap and saturate test: with CNT_W=4 and rx flag held high for 17 edges -> count = 1 in a wrap build, and 15 in an AURORA_HLS_MONITOR_SATURATE_EN build.
